instr_fetch_unit: RTL and testbench

- Fetch stage of the multicycle core. Consumes the phase strobes from the clock-phase counter: if_enable (fetch phase) and pc_write (write-back phase).
- Holds the program counter and runs a req/ack read of instruction memory.
- Latches the returned word into the instruction register for the decode stage.
- Applies sequential, branch or jump PC updates on pc_write.

---
 rtl/lapido_pkg.sv | 16 +
 rtl/instr_fetch_unit_pc_register.sv | 33 +++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lapido_pkg.sv
// Shared definitions for the instruction fetch slice: fetch state encoding,
// the NOP word used when a fetch is abandoned, and default bus widths.
package lapido_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 32;
   localparam int unsigned DEF_DATA_WIDTH = 32;

   // Word loaded into the instruction register when a fetch is aborted
   localparam logic [DEF_DATA_WIDTH-1:0] NOP_INSTR = '0;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter: reset to RESET_PC, updated only on pc_write with either
// the branch target or the sequential increment. pc_plus doubles as the
// link value for jump-and-link style instructions.
module pc_register
   import lapido_pkg::*;
#(
   parameter int unsigned              ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0,
   parameter int unsigned              PC_INC     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pc_write,
   input  logic                  branch_taken,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH-1:0] pc_plus
);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;

   // Increment wraps naturally modulo 2^ADDR_WIDTH
   assign pc_plus = pc_q + ADDR_WIDTH'(PC_INC);
   assign pc_d    = branch_taken ? branch_target : pc_plus;
   assign pc      = pc_q;

   // PC flop; branch_taken only matters on pc_write edges
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         pc_q <= RESET_PC;
      else if (pc_write) pc_q <= pc_d;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multicycle core. Holds the PC (via pc_register), runs a
// req/ack read of instruction memory on the fetch-phase strobe and latches
// the returned word into the instruction register.
// Optional watchdog: define IFETCH_TIMEOUT_EN to abort fetches that wait
// longer than TIMEOUT_CYCLES cycles for an ack (sets sticky fetch_err).
module instr_fetch_unit
   import lapido_pkg::*;
#(
   parameter int unsigned              ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int unsigned              DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter logic [ADDR_WIDTH-1:0]    RESET_PC       = '0,
   parameter int unsigned              PC_INC         = 1,
   parameter int unsigned              TIMEOUT_CYCLES = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_enable,
   input  logic                  pc_write,
   input  logic                  branch_taken,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  imem_ack,
   output logic [DATA_WIDTH-1:0] ir,
   output logic                  ir_valid,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH-1:0] pc_plus,
   output logic                  fetch_busy,
   output logic                  fetch_err
);

   fetch_state_e          state_q;
   logic                  req_q, busy_q, ir_valid_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] ir_q;

   pc_register #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   (RESET_PC),
      .PC_INC     (PC_INC)
   ) u_pc (
      .clk           (clk),
      .rst           (rst),
      .pc_write      (pc_write),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .pc            (pc),
      .pc_plus       (pc_plus)
   );

`ifdef IFETCH_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;
   assign fetch_err = err_q;
`else
   assign fetch_err = 1'b0;
`endif

   // Fetch FSM: address is captured from the pre-update pc, so a pc_write on
   // the same edge never disturbs the fetch in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         addr_q     <= '0;
         busy_q     <= 1'b0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
         cnt_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               // Stray acks in IDLE fall through here untouched
               if (if_enable) begin
                  state_q    <= FETCH;
                  addr_q     <= pc;
                  req_q      <= 1'b1;
                  busy_q     <= 1'b1;
                  ir_valid_q <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
                  cnt_q      <= '0;
`endif
               end
            end
            FETCH: begin
               // Ack wins over the watchdog on the same edge
               if (imem_ack) begin
                  state_q    <= IDLE;
                  ir_q       <= imem_rdata;
                  ir_valid_q <= 1'b1;
                  req_q      <= 1'b0;
                  busy_q     <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
               end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                  state_q    <= IDLE;
                  ir_q       <= DATA_WIDTH'(NOP_INSTR);
                  ir_valid_q <= 1'b1;
                  req_q      <= 1'b0;
                  busy_q     <= 1'b0;
                  err_q      <= 1'b1;
               end else begin
                  cnt_q      <= cnt_q + 1'b1;
`endif
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = addr_q;
   assign fetch_busy = busy_q;
   assign ir         = ir_q;
   assign ir_valid   = ir_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. Inputs change on the falling
// edge, outputs are checked on the falling edge after the rising edge.
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h100;
   localparam int          TO     = 4;

   logic        clk = 1'b0, rst = 1'b0;
   logic        if_enable = 1'b0, pc_write = 1'b0, branch_taken = 1'b0;
   logic [31:0] branch_target = '0, imem_rdata = '0;
   logic        imem_ack = 1'b0;
   logic        imem_req, ir_valid, fetch_busy, fetch_err;
   logic [31:0] imem_addr, ir, pc, pc_plus;

   int          n_cmp = 0, n_err = 0;
   logic [31:0] m_pc = RST_PC;   // reference pc
   logic [31:0] m_ir = '0;       // reference instruction register
   logic        exp_err = 1'b0;

   instr_fetch_unit #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RST_PC), .PC_INC(1), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .if_enable(if_enable), .pc_write(pc_write),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_ack(imem_ack), .ir(ir), .ir_valid(ir_valid), .pc(pc), .pc_plus(pc_plus),
      .fetch_busy(fetch_busy), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      tick(); tick();
      n_cmp++; if (pc !== RST_PC) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
      n_cmp++; if (ir !== 32'h0) begin n_err++; $display("FAIL reset_ir: got %h want 0", ir); end
      n_cmp++; if ({ir_valid, imem_req, fetch_busy, fetch_err} !== 4'b0000) begin
         n_err++; $display("FAIL reset_flags: got %b want 0000", {ir_valid, imem_req, fetch_busy, fetch_err}); end
      n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
      rst = 1'b1;
      m_pc = RST_PC;
      tick();
   endtask

   task automatic test_zero_wait;
      if_enable = 1'b1; tick(); if_enable = 1'b0;
      n_cmp++; if (imem_req !== 1'b1 || fetch_busy !== 1'b1 || ir_valid !== 1'b0) begin
         n_err++; $display("FAIL zw_req: got req=%b busy=%b irv=%b want 1 1 0", imem_req, fetch_busy, ir_valid); end
      n_cmp++; if (imem_addr !== m_pc) begin n_err++; $display("FAIL zw_addr: got %h want %h", imem_addr, m_pc); end
      imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF; tick(); imem_ack = 1'b0;
      m_ir = 32'hDEADBEEF;
      n_cmp++; if (ir !== m_ir || ir_valid !== 1'b1) begin
         n_err++; $display("FAIL zw_ir: got %h/%b want %h/1", ir, ir_valid, m_ir); end
      n_cmp++; if (imem_req !== 1'b0 || fetch_busy !== 1'b0) begin
         n_err++; $display("FAIL zw_done: got req=%b busy=%b want 0 0", imem_req, fetch_busy); end
   endtask

   task automatic test_wait_ack;
      logic [31:0] d;
      d = $urandom;
      if_enable = 1'b1; tick(); if_enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            n_err++; $display("FAIL wait_hold%0d: got req=%b addr=%h want 1 %h", i, imem_req, imem_addr, m_pc); end
         if_enable = (i == 1);   // extra strobe mid-fetch must be dropped
         if (i == 3) begin imem_ack = 1'b1; imem_rdata = d; end
         tick();
      end
      imem_ack = 1'b0; if_enable = 1'b0;
      m_ir = d;
      n_cmp++; if (ir !== m_ir || ir_valid !== 1'b1) begin
         n_err++; $display("FAIL wait_ir: got %h/%b want %h/1", ir, ir_valid, m_ir); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (imem_req !== 1'b0 || fetch_busy !== 1'b0 || ir_valid !== 1'b1) begin
            n_err++; $display("FAIL wait_single%0d: got req=%b busy=%b irv=%b want 0 0 1", i, imem_req, fetch_busy, ir_valid); end
      end
   endtask

   task automatic test_phase_seq(input logic br, input logic [31:0] tgt, input logic [31:0] want);
      logic [31:0] d;
      d = $urandom;
      if_enable = 1'b1; tick(); if_enable = 1'b0;                  // phase 0
      imem_ack = 1'b1; imem_rdata = d; tick(); imem_ack = 1'b0;    // phase 1
      tick(); tick();                                              // phases 2,3
      pc_write = 1'b1; branch_taken = br; branch_target = tgt;
      tick();                                                      // phase 4
      pc_write = 1'b0; branch_taken = 1'b0;
      m_ir = d; m_pc = want;
      n_cmp++; if (pc !== want) begin n_err++; $display("FAIL phase_pc(br=%b): got %h want %h", br, pc, want); end
      n_cmp++; if (ir !== m_ir) begin n_err++; $display("FAIL phase_ir: got %h want %h", ir, m_ir); end
   endtask

   task automatic test_simultaneous;
      pc_write = 1'b1; branch_taken = 1'b1; branch_target = 32'h20; tick();
      pc_write = 1'b1; branch_taken = 1'b0; if_enable = 1'b1; tick();
      pc_write = 1'b0; if_enable = 1'b0;
      n_cmp++; if (imem_addr !== 32'h20) begin n_err++; $display("FAIL simul_addr: got %h want 00000020", imem_addr); end
      n_cmp++; if (pc !== 32'h21) begin n_err++; $display("FAIL simul_pc: got %h want 00000021", pc); end
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678; tick(); imem_ack = 1'b0;
      m_ir = 32'h1234_5678;
      pc_write = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF; tick();
      branch_taken = 1'b0; tick();
      pc_write = 1'b0;
      n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want 0", pc); end
      n_cmp++; if (pc_plus !== 32'h1) begin n_err++; $display("FAIL wrap_pc_plus: got %h want 1", pc_plus); end
      m_pc = 32'h0;
   endtask

   task automatic test_async_reset;
      if_enable = 1'b1; tick(); if_enable = 1'b0;
      n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL arst_pre: got req=%b want 1", imem_req); end
      #1 rst = 1'b0;
      #1;
      n_cmp++; if (imem_req !== 1'b0 || pc !== RST_PC) begin
         n_err++; $display("FAIL arst_drop: got req=%b pc=%h want 0 %h", imem_req, pc, RST_PC); end
      @(negedge clk); rst = 1'b1;
      imem_ack = 1'b1; imem_rdata = $urandom; tick(); imem_ack = 1'b0;
      m_pc = RST_PC; m_ir = '0; exp_err = 1'b0;
      n_cmp++; if (ir !== 32'h0 || ir_valid !== 1'b0 || imem_req !== 1'b0) begin
         n_err++; $display("FAIL arst_ack: got ir=%h irv=%b req=%b want 0 0 0", ir, ir_valid, imem_req); end
   endtask

`ifdef IFETCH_TIMEOUT_EN
   task automatic test_timeout;
      if_enable = 1'b1; tick(); if_enable = 1'b0;
      for (int i = 0; i <= TO; i++) begin
         n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL to_wait%0d: got req=%b want 1", i, imem_req); end
         tick();
      end
      exp_err = 1'b1; m_ir = '0;
      n_cmp++; if (imem_req !== 1'b0 || ir !== 32'h0 || ir_valid !== 1'b1 || fetch_err !== 1'b1) begin
         n_err++; $display("FAIL to_abort: got req=%b ir=%h irv=%b err=%b want 0 0 1 1", imem_req, ir, ir_valid, fetch_err); end
      if_enable = 1'b1; tick(); if_enable = 1'b0;
      imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D; tick(); imem_ack = 1'b0;
      m_ir = 32'hCAFE_F00D;
      n_cmp++; if (ir !== m_ir || fetch_err !== 1'b1) begin
         n_err++; $display("FAIL to_sticky: got ir=%h err=%b want %h 1", ir, fetch_err, m_ir); end
   endtask
`endif

   task automatic test_random;
      logic [31:0] faddr, d, tgt;
      logic        early, br;
      int          dly;
      for (int it = 0; it < 20; it++) begin
         early = 1'($urandom_range(0, 1));
         br    = 1'($urandom_range(0, 1));
         tgt   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         d     = $urandom;
         dly   = $urandom_range(0, 4);
         faddr = m_pc;
         if_enable = 1'b1;
         if (early) begin pc_write = 1'b1; branch_taken = br; branch_target = tgt; end
         tick();
         if_enable = 1'b0; pc_write = 1'b0;
         if (early) m_pc = br ? tgt : m_pc + 32'd1;
         for (int w = 0; w < dly; w++) begin
            branch_taken = 1'($urandom_range(0, 1));   // must be ignored without pc_write
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== faddr || pc !== m_pc) begin
               n_err++; $display("FAIL rnd_wait%0d: got req=%b addr=%h pc=%h want 1 %h %h", it, imem_req, imem_addr, pc, faddr, m_pc); end
            tick();
         end
         imem_ack = 1'b1; imem_rdata = d; tick();
         m_ir = d;
         imem_rdata = ~d; tick();                       // stray ack in IDLE
         imem_ack = 1'b0;
         n_cmp++; if (ir !== m_ir || ir_valid !== 1'b1 || imem_req !== 1'b0) begin
            n_err++; $display("FAIL rnd_ir%0d: got %h/%b/%b want %h/1/0", it, ir, ir_valid, imem_req, m_ir); end
         if (!early) begin
            pc_write = 1'b1; branch_taken = br; branch_target = tgt; tick();
            pc_write = 1'b0;
            m_pc = br ? tgt : m_pc + 32'd1;
         end
         branch_taken = 1'b0;
         n_cmp++; if (pc !== m_pc || pc_plus !== m_pc + 32'd1 || fetch_err !== exp_err) begin
            n_err++; $display("FAIL rnd_pc%0d: got pc=%h plus=%h err=%b want %h %h %b", it, pc, pc_plus, fetch_err, m_pc, m_pc + 32'd1, exp_err); end
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_ack();
      test_phase_seq(1'b0, 32'h0, 32'h101);
      test_phase_seq(1'b1, 32'h40, 32'h40);
      test_simultaneous();
      test_async_reset();
`ifdef IFETCH_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
